// File: rtl/precision_pkg.sv
// Shared types and helpers for the matrix precision datapath blocks.
package precision_pkg;

  // Matrix-buffer occupancy: the number of complete matrices held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // Width of an index that must address n entries. It never returns zero,
  // so a one-entry dimension still has a legal one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_pingpong_buf.sv
// Two whole-matrix buffers used ping-pong: one is written in a single cycle,
// and one element is read combinationally by (buffer, row, col).
module matrix_pingpong_buf
  import precision_pkg::*;
#(
  parameter  int BITS = 16,
  parameter  int N    = 3,
  parameter  int M    = 2,
  localparam int RW   = idx_w(N),
  localparam int CW   = idx_w(M)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we_i,
  input  logic                          wp_i,
  input  logic [N-1:0][M-1:0][BITS-1:0] wdata_i,
  input  logic                          rp_i,
  input  logic [RW-1:0]                 row_i,
  input  logic [CW-1:0]                 col_i,
  output logic [BITS-1:0]               rdata_o
);

  logic [1:0][N-1:0][M-1:0][BITS-1:0] mem_q;

  // Capture a whole matrix into the buffer selected by the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffers are flops, not RAM, and must read as zero straight
      // after reset, so they are cleared here rather than left undefined.
      mem_q <= '0;
    end else if (we_i) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      mem_q[wp_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rp_i][row_i][col_i];

endmodule

// File: rtl/matrix_serializer.sv
// Captures a whole N x M matrix on a one-cycle pulse, holds up to two, and
// streams them one element per cycle in row-major order over valid/ready.
module matrix_serializer
  import precision_pkg::*;
#(
  parameter  int BITS = 16,
  parameter  int N    = 3,
  parameter  int M    = 2,
  localparam int RW   = idx_w(N),
  localparam int CW   = idx_w(M)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [N-1:0][M-1:0][BITS-1:0] a,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BITS-1:0]               out_data,
  output logic [RW-1:0]                 out_row,
  output logic [CW-1:0]                 out_col,
  output logic                          out_last,
  output logic                          overflow
);

  occ_t          occ_q, occ_d;
  logic          wp_q, wp_d;
  logic          rp_q, rp_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          overflow_q, overflow_d;

  logic          wr_en;
  logic          drop;
  logic          hs;
  logic          elem_last;
  logic          last_hs;

  // The producer cannot be stalled, so readiness depends on stored state only.
  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != EMPTY);
  assign wr_en     = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;
  assign hs        = out_valid && out_ready;
  assign elem_last = (row_q == RW'(N - 1)) && (col_q == CW'(M - 1));
  assign last_hs   = hs && elem_last;

  // Gated so a 1x1 matrix does not show out_last while nothing is valid.
  assign out_last = out_valid && elem_last;
  assign out_row  = row_q;
  assign out_col  = col_q;
  assign overflow = overflow_q;

  matrix_pingpong_buf #(
    .BITS (BITS),
    .N    (N),
    .M    (M)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .wp_i    (wp_q),
    .wdata_i (a),
    .rp_i    (rp_q),
    .row_i   (row_q),
    .col_i   (col_q),
    .rdata_o (out_data)
  );

  // Next occupancy, pointers, element counters and the sticky drop flag.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    occ_d      = occ_q;
    wp_d       = wp_q ^ wr_en;
    rp_d       = rp_q ^ last_hs;
    row_d      = row_q;
    col_d      = col_q;
    overflow_d = overflow_q | drop;

    case (occ_q)
      EMPTY: if (wr_en) occ_d = ONE;
      ONE: begin
        if (wr_en && !last_hs)      occ_d = FULL;
        else if (!wr_en && last_hs) occ_d = EMPTY;
      end
      // A write is impossible here, so a freed buffer always drops to ONE.
      FULL:    if (last_hs) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase

    if (hs) begin
      if (elem_last) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == CW'(M - 1)) begin
        row_d = row_q + RW'(1);
        col_d = '0;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // State register; reset drops all stored matrices and any partial stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= EMPTY;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_matrix_serializer.sv
// Scoreboard bench: stimulus pushes expected elements, monitors pop and compare.
module tb_matrix_serializer;

  localparam int BITS = 16;
  localparam int N    = 3;
  localparam int M    = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  row;
    logic [0:0]  col;
    logic        last;
  } elem_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main 3x2 instance
  logic                          in_valid  = 1'b0;
  logic [N-1:0][M-1:0][BITS-1:0] a         = '0;
  logic                          out_ready = 1'b0;
  logic                          in_ready, out_valid, out_last, overflow;
  logic [BITS-1:0]               out_data;
  logic [1:0]                    out_row;
  logic [0:0]                    out_col;

  // Degenerate 1x1 instance
  logic                    in_valid1  = 1'b0;
  logic [0:0][0:0][15:0]   a1         = '0;
  logic                    out_ready1 = 1'b1;
  logic                    in_ready1, out_valid1, out_last1, overflow1;
  logic [15:0]             out_data1;
  logic [0:0]              out_row1, out_col1;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  elem_t       exp_q[$];
  logic [15:0] exp1_q[$];

  matrix_serializer #(.BITS(BITS), .N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .overflow(overflow)
  );

  matrix_serializer #(.BITS(16), .N(1), .M(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_row(out_row1), .out_col(out_col1), .out_last(out_last1), .overflow(overflow1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Matrix tagged with id: element (r,c) = 16'hR<id>C<id>.
  function automatic logic [N-1:0][M-1:0][BITS-1:0] mk(input logic [3:0] id);
    logic [N-1:0][M-1:0][BITS-1:0] m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        m[r][c] = {4'(r), id, 4'(c), id};
    return m;
  endfunction

  task automatic push_exp(input logic [3:0] id);
    elem_t e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) begin
        e.data = {4'(r), id, 4'(c), id};
        e.row  = 2'(r);
        e.col  = 1'(c);
        e.last = (r == N - 1) && (c == M - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("reset_overflow", 64'(overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor for the 3x2 instance: element order/content and hold-while-stalled.
  elem_t mon_cur, mon_held;
  bit    mon_stalled = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_stalled = 0;
    end else begin
      mon_cur = {out_data, out_row, out_col, out_last};
      if (mon_stalled) check("hold_stable", {out_valid, mon_cur}, {1'b1, mon_held});
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_elem at %0t: got %0h expected none", $time, mon_cur);
        end else begin
          check("elem", mon_cur, exp_q.pop_front());
        end
      end
      mon_stalled = out_valid && !out_ready;
      mon_held    = mon_cur;
    end
  end

  // Monitor for the 1x1 instance: every element is (0,0) and last.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_elem1 at %0t: got %0h expected none", $time, out_data1);
      end else begin
        check("elem1", {out_data1, out_row1, out_col1, out_last1},
              {exp1_q.pop_front(), 1'b0, 1'b0, 1'b1});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_outputs", {out_data, out_row, out_col, out_last}, 0);
    check("rst1_flags", {out_valid1, in_ready1, out_last1, overflow1}, 4'b0100);
    tick();
    tick();
    rst_n = 1'b1;

    // Single matrix, out_ready held high: 6 valid cycles then idle
    out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b1;
    a        = mk(4'h0);
    push_exp(4'h0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_valid", 64'(out_valid), 1);
    end
    @(negedge clk);
    check("t1_idle_valid", 64'(out_valid), 0);
    check("t1_idle_ready", 64'(in_ready), 1);
    drain();

    // Backpressure: out_ready pattern 1,0,0,1
    begin
      int h0;
      h0 = hs_cnt;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = mk(4'h1);
      push_exp(4'h1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 24; i++) begin
        out_ready = (i % 4 == 0) || (i % 4 == 3);
        tick();
      end
      out_ready = 1'b1;
      drain();
      check("t2_handshakes", 64'(hs_cnt - h0), 6);
    end

    // Back-to-back A,B then C after a gap: C dropped, 12 elements with no gap
    out_ready = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      in_valid = (k == 0) || (k == 1) || (k == 3);
      a        = (k == 0) ? mk(4'h2) : (k == 1) ? mk(4'h3) : mk(4'h4);
      if (k == 0) push_exp(4'h2);
      if (k == 1) push_exp(4'h3);
      tick();
      @(negedge clk);
      in_valid = 1'b0;
      if (k < 12) check("t3_no_gap", 64'(out_valid), 1);
      else        check("t3_done", 64'(out_valid), 0);
      if (k == 1) check("t3_full_ready", 64'(in_ready), 0);
      if (k == 2) check("t3_no_overflow_yet", 64'(overflow), 0);
      if (k == 3) check("t3_overflow", 64'(overflow), 1);
    end
    drain();

    // Boundary freeing: pulse at A's last handshake is rejected, next cycle accepted
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k == 0) || (k == 1) || (k == 6) || (k == 7);
      a        = (k == 0) ? mk(4'h5) : (k == 1) ? mk(4'h6) : (k == 6) ? mk(4'h7) : mk(4'h8);
      if (k == 0) push_exp(4'h5);
      if (k == 1) push_exp(4'h6);
      if (k == 7) push_exp(4'h8);
      tick();
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 1) check("t4_full", 64'(in_ready), 0);
      if (k == 5) check("t4_overflow_before", 64'(overflow), 0);
      if (k == 6) check("t4_rejected_at_free", {overflow, in_ready}, 2'b11);
      if (k == 7) check("t4_accepted_after", {overflow, in_ready}, 2'b10);
    end
    drain();

    // Reset mid-stream after element (1,0) of the first of two stored matrices
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      in_valid = (k <= 2);
      a        = (k == 0) ? mk(4'h9) : (k == 1) ? mk(4'hA) : mk(4'hB);
      if (k == 0) push_exp(4'h9);
      if (k == 1) push_exp(4'hA);
      tick();
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 2) check("t5_overflow_set", 64'(overflow), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_async_valid", 64'(out_valid), 0);
    check("t5_outputs_zero", {out_data, out_row, out_col, out_last, overflow}, 0);
    check("t5_in_ready", 64'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    a        = mk(4'hC);
    push_exp(4'hC);
    tick();
    in_valid = 1'b0;
    drain();

    // Degenerate 1x1: one matrix per cycle, in_ready never drops
    out_ready1 = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      in_valid1 = (k < 4);
      a1[0][0]  = 16'hA000 + 16'(k);
      if (k < 4) exp1_q.push_back(16'hA000 + 16'(k));
      tick();
      @(negedge clk);
      in_valid1 = 1'b0;
      check("t6_in_ready", 64'(in_ready1), 1);
      if (k < 4) check("t6_valid", 64'(out_valid1), 1);
      else       check("t6_idle", 64'(out_valid1), 0);
    end
    tick();
    check("t6_queue_empty", 64'(exp1_q.size()), 0);
    check("t6_no_overflow", 64'(overflow1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_serializer.md
# matrix_serializer

Consumer for the parallel matrix arithmetic blocks. It captures a whole BITS-wide N×M matrix on a single-cycle `in_valid` pulse from a producer such as the matrix adder, which has no backpressure. It buffers up to two matrices and streams them out one element per cycle, row-major, over a valid/ready handshake. It sits between the wide-parallel precision datapath and narrow element-wise consumers such as memory writers, formatters and UART dumps.

## Interface
Parameters:
- `BITS`, 16, element width; data is opaque and is never interpreted as floating point.
- `N`, 3, rows.
- `M`, 2, columns.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  one-cycle pulse; `a` is valid this cycle.
- `a`  in  BITS×[N][M]  input matrix.
- `in_ready`  out  1  at least one matrix buffer is free.
- `out_valid`  out  1  `out_data` holds a valid element.
- `out_ready`  in  1  downstream accepts the element.
- `out_data`  out  BITS  current element.
- `out_row`  out  RW  row index of `out_data`.
- `out_col`  out  CW  column index of `out_data`.
- `out_last`  out  1  element is (N-1, M-1).
- `overflow`  out  1  sticky; a matrix was dropped.

Index widths:
- RW = N>1 ? $clog2(N) : 1
- CW = M>1 ? $clog2(M) : 1

## Operation
Storage:
- Two matrix buffers, B0 and B1, used ping-pong.
- Write pointer `wp`, read pointer `rp`, occupancy `cnt` ∈ {0,1,2}.
- `cnt` is the state machine: EMPTY(0), ONE(1), FULL(2).

Write:
- `in_ready = (cnt != 2)`. It is combinational from registered state only and does not depend on `out_ready`.
- `in_valid && in_ready`: copy `a` into B[wp], toggle `wp`, increment `cnt`.
- `in_valid && !in_ready`: discard the matrix, set `overflow`. Stored data and `cnt` are unchanged.

Read:
- `out_valid = (cnt != 0)`.
- `out_data = B[rp][row][col]`, `out_row = row`, `out_col = col`, `out_last = (row==N-1 && col==M-1)`.
- On a handshake (`out_valid && out_ready`):
  - col increments.
  - At col==M-1, col goes to 0 and row increments.
  - At the last element, row and col go to 0, `rp` toggles and `cnt` decrements, freeing the buffer.

Transitions:
- EMPTY→ONE on write.
- ONE→FULL on write without a last-element handshake.
- ONE→EMPTY on a last-element handshake without a write.
- FULL→ONE on a last-element handshake.
- A write and a last-element handshake in the same cycle leave `cnt` unchanged and move both pointers.
- In FULL, a last-element handshake frees a buffer, but `in_valid` in that same cycle is still rejected, because `in_ready` was 0.

Other rules:
- While `out_valid && !out_ready`, all out_* signals are held stable.
- A buffer under read is never overwritten.
- `overflow` clears only on reset.

## Timing
Reset (async assert) values:
- `out_valid`=0, `in_ready`=1, `overflow`=0.
- `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0.
- `cnt`=0, `wp`=`rp`=0, row=col=0; buffer contents are zeroed.

Reset mid-stream:
- All stored matrices are lost.
- `out_valid` falls asynchronously.
- No partial stream resumes after reset.

Latency and throughput:
- Matrix accepted at edge t: first element is presented with `out_valid`=1 in the cycle after t, if `cnt` was 0.
- With `out_ready` held at 1, one element per cycle and N·M cycles per matrix.
- Back-to-back matrices stream with no bubble between element (N-1,M-1) of one and (0,0) of the next.
- Sustained input rate without overflow: one matrix per N·M cycles. Two matrices may arrive back-to-back.

## Structure
- Shared package `precision_pkg`:
  - function `idx_w(n)` returning n>1 ? $clog2(n) : 1.
  - enum `occ_t` {EMPTY, ONE, FULL}.
- One natural sub-module, `matrix_pingpong_buf`:
  - Holds the two BITS×[N][M] arrays.
  - Ports: write enable plus `wp`, and read address (`rp`, row, col).
  - Async reset to zero.
- Top level holds the occupancy FSM, the row/col counters and `overflow`.

## Test plan
All scenarios use N=3, M=2, BITS=16; elements are 16'hR0C0-style tags (e.g. (1,0)=16'h1000).
- Single matrix, `out_ready`=1: in_valid at cycle 5. The stream runs cycles 6–11 in order (0,0),(0,1),(1,0),(1,1),(2,0),(2,1). `out_last` is asserted only at cycle 11. `cnt` returns to 0 and `out_valid`=0 at cycle 12.
- Backpressure: `out_ready` toggles 1,0,0,1 repeatedly. Each element is held stable while stalled. Six handshakes occur with no duplicates or skips.
- Back-to-back: matrices A and B are pulsed on consecutive cycles, then C arrives one cycle later. `in_ready`=0 after B, so C is dropped and `overflow`=1. Twelve elements A then B are emitted with no gap.
- Boundary freeing: the FULL state is entered with `out_ready`=1. A new matrix pulsed in the same cycle as A's last-element handshake is rejected (`overflow` set). The same pulse one cycle later is accepted.
- Reset mid-stream: `rst_n` is asserted low after element (1,0) of the first of two stored matrices. `out_valid` drops immediately, all outputs go to 0 and `overflow`=0. After release, a new matrix streams from (0,0).
- Degenerate size N=1, M=1: every element has `out_last`=1. Back-to-back pulses output at one matrix per cycle, and `in_ready` never drops with `out_ready`=1.
